// File: rtl/tx_port_channel_gate_sc.sv
// TX channel gate: frames one channel transaction (LEN hdr, OFF/LAST hdr, data beats,
// word-count end marker) into a first-word-fall-through FIFO, never accepting beats past LEN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for registered CHNL_TX; queues LEN header
// HDR_OFF | queues OFF/LAST header, pulses ACK
// OPEN    | accepting data beats until LEN words or CHNL_TX drops
// CLOSE   | queues end marker carrying the accepted word count
module tx_port_channel_gate_sc #(
  parameter int  C_DATA_WIDTH      = 32,
  parameter int  C_FIFO_DEPTH      = 8,
  localparam int C_FIFO_DATA_WIDTH = C_DATA_WIDTH + 1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  output logic [C_FIFO_DATA_WIDTH-1:0] RD_DATA,
  output logic                         RD_EMPTY,
  input  logic                         RD_EN,
  input  logic                         CHNL_TX,
  output logic                         CHNL_TX_ACK,
  input  logic                         CHNL_TX_LAST,
  input  logic [31:0]                  CHNL_TX_LEN,
  input  logic [30:0]                  CHNL_TX_OFF,
  input  logic [C_DATA_WIDTH-1:0]      CHNL_TX_DATA,
  input  logic                         CHNL_TX_DATA_VALID,
  output logic                         CHNL_TX_DATA_REN
);

  localparam int          W        = C_DATA_WIDTH / 32;
  localparam int          AW       = $clog2(C_FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(C_FIFO_DEPTH - 1);
  localparam logic [32:0] W_INC    = 33'(W);

  typedef enum logic [1:0] {S_IDLE, S_HDR_OFF, S_OPEN, S_CLOSE} state_e;

  state_e                         state_q, state_d;
  logic                           tx_q, tx_d, last_q, last_d;
  logic [31:0]                    len_q, len_d, limit_q, limit_d, count_q, count_d;
  logic [30:0]                    off_q, off_d;
  logic                           ack_q, ack_d, wr_q, wr_d;
  logic [C_FIFO_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [C_FIFO_DATA_WIDTH-1:0]   mem_q [C_FIFO_DEPTH];
  logic [AW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                    level_q, level_d;
  logic                           full, empty, pop, ren;
  logic [32:0]                    count_inc;
  logic [31:0]                    count_sat;
  logic [C_DATA_WIDTH-1:0]        pay;

  // Full leaves one slot spare because writes land a cycle after the decision.
  assign full      = (level_q >= FULL_LVL);
  assign empty     = (level_q == '0);
  assign pop       = RD_EN & ~empty;
  assign count_inc = {1'b0, count_q} + W_INC;
  assign count_sat = count_inc[32] ? 32'hFFFF_FFFF : count_inc[31:0];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b0;
      last_q    <= 1'b0;
      len_q     <= '0;
      off_q     <= '0;
      limit_q   <= '0;
      count_q   <= '0;
      ack_q     <= 1'b0;
      wr_q      <= 1'b0;
      wr_data_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      last_q    <= last_d;
      len_q     <= len_d;
      off_q     <= off_d;
      limit_q   <= limit_d;
      count_q   <= count_d;
      ack_q     <= ack_d;
      wr_q      <= wr_d;
      wr_data_q <= wr_data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      if (wr_q) mem_q[wr_ptr_q] <= wr_data_q;
    end
  end

  always_comb begin
    tx_d     = CHNL_TX;
    last_d   = CHNL_TX_LAST;
    len_d    = CHNL_TX_LEN;
    off_d    = CHNL_TX_OFF;
    wr_ptr_d = wr_q ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({wr_q, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (tx_q && !full) state_d = S_HDR_OFF;
      S_HDR_OFF: if (!full)         state_d = tx_q ? S_OPEN : S_CLOSE;
      S_OPEN:    if (!tx_q)         state_d = S_CLOSE;
      S_CLOSE:   if (!full)         state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ren       = 1'b0;
    ack_d     = 1'b0;
    wr_d      = 1'b0;
    wr_data_d = '0;
    pay       = '0;
    count_d   = count_q;
    limit_d   = limit_q;
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (tx_q && !full) begin
          wr_d       = 1'b1;
          pay[31:0]  = len_q;
          wr_data_d  = {1'b1, pay};
          limit_d    = len_q;
        end
      end
      S_HDR_OFF: begin
        if (!full) begin
          wr_d      = 1'b1;
          pay[31:0] = {off_q, last_q};
          wr_data_d = {1'b1, pay};
          ack_d     = 1'b1;
        end
      end
      S_OPEN: begin
        ren = !full && CHNL_TX && tx_q && (count_q < limit_q);
        if (ren && CHNL_TX_DATA_VALID) begin
          wr_d      = 1'b1;
          wr_data_d = {1'b0, CHNL_TX_DATA};
          count_d   = count_sat;
        end
      end
      S_CLOSE: begin
        if (!full) begin
          wr_d      = 1'b1;
          pay[31:0] = count_q;
          wr_data_d = {1'b1, pay};
        end
      end
      default: ;
    endcase
  end

  assign RD_DATA          = empty ? '0 : mem_q[rd_ptr_q];
  assign RD_EMPTY         = empty;
  assign CHNL_TX_ACK      = ack_q;
  assign CHNL_TX_DATA_REN = ren;

endmodule

// File: tb/tb_tx_port_channel_gate_sc.sv
// Directed bench for the TX channel gate: a 32-bit and a 128-bit instance, each with a
// capture queue on the read side compared against hand-built expected word lists.
module tb_tx_port_channel_gate_sc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        rd_en_a, rd_empty_a, tx_a, ack_a, last_a, valid_a, ren_a;
  logic [32:0] rd_data_a;
  logic [31:0] len_a, data_a;
  logic [30:0] off_a;

  logic         rd_en_b, rd_empty_b, tx_b, ack_b, last_b, valid_b, ren_b;
  logic [128:0] rd_data_b;
  logic [31:0]  len_b;
  logic [30:0]  off_b;
  logic [127:0] data_b;

  int n_tests = 0;
  int n_fail  = 0;
  int beats_a = 0, beats_b = 0, acks_a = 0, acks_b = 0;
  int s;

  logic [32:0]  got_a [$];
  logic [32:0]  exp_a [$];
  logic [128:0] got_b [$];
  logic [128:0] exp_b [$];

  tx_port_channel_gate_sc #(.C_DATA_WIDTH(32), .C_FIFO_DEPTH(8)) u_a (
    .CLK(clk), .RST_N(rst_n), .RD_DATA(rd_data_a), .RD_EMPTY(rd_empty_a), .RD_EN(rd_en_a),
    .CHNL_TX(tx_a), .CHNL_TX_ACK(ack_a), .CHNL_TX_LAST(last_a), .CHNL_TX_LEN(len_a),
    .CHNL_TX_OFF(off_a), .CHNL_TX_DATA(data_a), .CHNL_TX_DATA_VALID(valid_a),
    .CHNL_TX_DATA_REN(ren_a)
  );

  tx_port_channel_gate_sc #(.C_DATA_WIDTH(128), .C_FIFO_DEPTH(8)) u_b (
    .CLK(clk), .RST_N(rst_n), .RD_DATA(rd_data_b), .RD_EMPTY(rd_empty_b), .RD_EN(rd_en_b),
    .CHNL_TX(tx_b), .CHNL_TX_ACK(ack_b), .CHNL_TX_LAST(last_b), .CHNL_TX_LEN(len_b),
    .CHNL_TX_OFF(off_b), .CHNL_TX_DATA(data_b), .CHNL_TX_DATA_VALID(valid_b),
    .CHNL_TX_DATA_REN(ren_b)
  );

  function automatic logic [31:0] beat32(input int k);
    return 32'hA000_0000 + 32'(k);
  endfunction

  function automatic logic [127:0] beat128(input int k);
    logic [31:0] b;
    b = 32'hB000_0000 + 32'(4 * k);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // Data presented always corresponds to the next beat number to be accepted.
  assign data_a = beat32(beats_a);
  assign data_b = beat128(beats_b);

  always @(posedge clk) begin
    if (rd_en_a && !rd_empty_a) got_a.push_back(rd_data_a);
    if (rd_en_b && !rd_empty_b) got_b.push_back(rd_data_b);
    if (ren_a && valid_a) beats_a <= beats_a + 1;
    if (ren_b && valid_b) beats_b <= beats_b + 1;
    if (ack_a) acks_a <= acks_a + 1;
    if (ack_b) acks_b <= acks_b + 1;
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats_a(input int n, input string tag);
    int k = 0;
    while (beats_a < n && k < 200) begin tick(); k++; end
    chk(tag, 160'(beats_a >= n), 160'(1));
  endtask

  task automatic wait_beats_b(input int n, input string tag);
    int k = 0;
    while (beats_b < n && k < 200) begin tick(); k++; end
    chk(tag, 160'(beats_b >= n), 160'(1));
  endtask

  task automatic drain_a(input string tag);
    int k = 0;
    while (got_a.size() < exp_a.size() && k < 300) begin tick(); k++; end
    repeat (3) tick();
    chk({tag, "_count"}, 160'(got_a.size()), 160'(exp_a.size()));
    for (int i = 0; i < exp_a.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), (i < got_a.size()) ? 160'(got_a[i]) : '1, 160'(exp_a[i]));
    got_a.delete();
    exp_a.delete();
  endtask

  task automatic drain_b(input string tag);
    int k = 0;
    while (got_b.size() < exp_b.size() && k < 300) begin tick(); k++; end
    repeat (3) tick();
    chk({tag, "_count"}, 160'(got_b.size()), 160'(exp_b.size()));
    for (int i = 0; i < exp_b.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), (i < got_b.size()) ? 160'(got_b[i]) : '1, 160'(exp_b[i]));
    got_b.delete();
    exp_b.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    rd_en_a = 0; tx_a = 0; last_a = 0; len_a = '0; off_a = '0; valid_a = 0;
    rd_en_b = 0; tx_b = 0; last_b = 0; len_b = '0; off_b = '0; valid_b = 0;
    repeat (3) tick();
    chk("rst_empty",   160'(rd_empty_a), 160'(1));
    chk("rst_data",    160'(rd_data_a),  160'(0));
    chk("rst_ack",     160'(ack_a),      160'(0));
    chk("rst_ren",     160'(ren_a),      160'(0));
    chk("rst_empty_b", 160'(rd_empty_b), 160'(1));
    rst_n = 1'b1;
    tick();

    // Basic 4-word transaction, reader always on
    rd_en_a = 1; len_a = 32'd4; off_a = 31'd5; last_a = 1; valid_a = 1;
    s = beats_a;
    tx_a = 1;
    tick(); tick();
    chk("lat_ack_early",   160'(ack_a),      160'(0));
    chk("lat_empty_early", 160'(rd_empty_a), 160'(1));
    tick();
    chk("lat_empty", 160'(rd_empty_a), 160'(0));
    chk("lat_len",   160'(rd_data_a),  160'({1'b1, 32'd4}));
    chk("lat_ack",   160'(ack_a),      160'(1));
    wait_beats_a(s + 4, "t1_beats_to");
    repeat (3) tick();
    chk("t1_ren_capped", 160'(ren_a),       160'(0));
    chk("t1_beats",      160'(beats_a - s), 160'(4));
    tx_a = 0; valid_a = 0;
    exp_a.push_back({1'b1, 32'd4});
    exp_a.push_back({1'b1, 32'hB});
    for (int i = 0; i < 4; i++) exp_a.push_back({1'b0, beat32(s + i)});
    exp_a.push_back({1'b1, 32'd4});
    drain_a("t1");
    chk("t1_acks", 160'(acks_a), 160'(1));

    // One-cycle CHNL_TX pulse: open then close with no data
    len_a = 32'd7; off_a = 31'd3; last_a = 0;
    tx_a = 1;
    tick();
    tx_a = 0;
    exp_a.push_back({1'b1, 32'd7});
    exp_a.push_back({1'b1, 32'd6});
    exp_a.push_back({1'b1, 32'd0});
    drain_a("t2");
    chk("t2_acks", 160'(acks_a), 160'(2));

    // Reader stalled: FIFO fills, REN stops, then drains in order
    rd_en_a = 0; len_a = 32'd20; off_a = 31'd0; last_a = 0; valid_a = 1;
    s = beats_a;
    tx_a = 1;
    repeat (30) tick();
    chk("t3_ren_full", 160'(ren_a),         160'(0));
    chk("t3_beats",    160'(beats_a - s),   160'(6));
    chk("t3_nopop",    160'(got_a.size()),  160'(0));
    chk("t3_head",     160'(rd_data_a),     160'({1'b1, 32'd20}));
    rd_en_a = 1;
    wait_beats_a(s + 20, "t3_beats_to");
    tx_a = 0; valid_a = 0;
    exp_a.push_back({1'b1, 32'd20});
    exp_a.push_back({1'b1, 32'd0});
    for (int i = 0; i < 20; i++) exp_a.push_back({1'b0, beat32(s + i)});
    exp_a.push_back({1'b1, 32'd20});
    drain_a("t3");
    chk("t3_acks", 160'(acks_a), 160'(3));

    // Reset in OPEN with words queued, then a clean transaction
    rd_en_a = 0; len_a = 32'd10; valid_a = 1;
    s = beats_a;
    tx_a = 1;
    wait_beats_a(s + 1, "t4_beats_to");
    tick();
    rst_n = 0; tx_a = 0; valid_a = 0;
    tick();
    chk("t4_rst_empty", 160'(rd_empty_a), 160'(1));
    chk("t4_rst_ren",   160'(ren_a),      160'(0));
    chk("t4_rst_ack",   160'(ack_a),      160'(0));
    chk("t4_rst_data",  160'(rd_data_a),  160'(0));
    rst_n = 1;
    tick();
    chk("t4_post_empty", 160'(rd_empty_a), 160'(1));
    rd_en_a = 1; len_a = 32'd2; off_a = 31'd1; last_a = 0; valid_a = 1;
    s = beats_a;
    tx_a = 1;
    wait_beats_a(s + 2, "t4b_beats_to");
    tx_a = 0; valid_a = 0;
    exp_a.push_back({1'b1, 32'd2});
    exp_a.push_back({1'b1, 32'd2});
    for (int i = 0; i < 2; i++) exp_a.push_back({1'b0, beat32(s + i)});
    exp_a.push_back({1'b1, 32'd2});
    drain_a("t4");
    chk("t4_acks", 160'(acks_a), 160'(5));

    // 128-bit: LEN=6 takes two whole beats, count reports 8
    rd_en_b = 1; len_b = 32'd6; off_b = 31'd0; last_b = 0; valid_b = 1;
    s = beats_b;
    tx_b = 1;
    wait_beats_b(s + 2, "t5_beats_to");
    repeat (3) tick();
    chk("t5_ren_capped", 160'(ren_b),       160'(0));
    chk("t5_beats",      160'(beats_b - s), 160'(2));
    tx_b = 0; valid_b = 0;
    exp_b.push_back({1'b1, 128'd6});
    exp_b.push_back({1'b1, 128'd0});
    exp_b.push_back({1'b0, beat128(s)});
    exp_b.push_back({1'b0, beat128(s + 1)});
    exp_b.push_back({1'b1, 128'd8});
    drain_b("t5");
    chk("t5_acks", 160'(acks_b), 160'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
